// File: rtl/mem_intf_hs_pkg.sv
// Shared types for the MEM-stage load/store bus interface.
package mem_intf_hs_pkg;

  // Access size encodings as presented on i_size
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  // Transaction FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Per-access context held for the load return path
  typedef struct packed {
    logic  we;
    size_e size;
    logic  sgn;
  } acc_ctx_t;

endpackage

// File: rtl/mem_intf_hs_lane_align.sv
// Byte-lane steering: store byte enables/data, load extraction/extension, alignment check.
module mem_intf_hs_lane_align
  import mem_intf_hs_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned OFF_W = $clog2(DW / 8)
) (
  input  size_e                st_size,
  input  logic [OFF_W-1:0]     st_off,
  input  logic [DW-1:0]        st_data,
  input  size_e                ld_size,
  input  logic [OFF_W-1:0]     ld_off,
  input  logic                 ld_sgn,
  input  logic [DW-1:0]        ld_raw,
  output logic                 legal_c,
  output logic [DW/8-1:0]      be_c,
  output logic [DW-1:0]        st_data_c,
  output logic [DW-1:0]        ld_data_c
);

  localparam int unsigned BEW   = DW / 8;
  localparam int unsigned IDX_W = $clog2(DW);

  logic [BEW-1:0]   mask;
  logic [DW-1:0]    ld_shift;
  logic [IDX_W-1:0] sign_idx;
  logic             sign_bit;

  // Natural alignment check; dword only exists on a 64-bit bus
  always_comb begin
    legal_c = 1'b1;
    case (st_size)
      SZ_B:    legal_c = 1'b1;
      SZ_H:    legal_c = ~st_off[0];
      SZ_W:    legal_c = (st_off[1:0] == 2'b00);
      default: legal_c = (DW == 64) && (st_off == '0);
    endcase
  end

  // Store path: size mask and data shifted onto the addressed lanes
  always_comb begin
    mask = '0;
    case (st_size)
      SZ_B:    mask = BEW'(8'h01);
      SZ_H:    mask = BEW'(8'h03);
      SZ_W:    mask = BEW'(8'h0F);
      default: mask = BEW'(8'hFF);
    endcase
    be_c      = mask << st_off;
    st_data_c = st_data << {st_off, 3'b000};
  end

  // Load path: right-justify the addressed bytes, then sign/zero extend above the size
  always_comb begin
    ld_shift = ld_raw >> {ld_off, 3'b000};
    sign_idx = IDX_W'(DW - 1);
    case (ld_size)
      SZ_B:    sign_idx = IDX_W'(7);
      SZ_H:    sign_idx = IDX_W'(15);
      SZ_W:    sign_idx = IDX_W'((DW > 32) ? 31 : DW - 1);
      default: sign_idx = IDX_W'(DW - 1);
    endcase
    sign_bit  = ld_sgn & ld_shift[sign_idx];
    ld_data_c = '0;
    for (int i = 0; i < int'(DW); i++) begin
      ld_data_c[i] = (IDX_W'(i) <= sign_idx) ? ld_shift[i] : sign_bit;
    end
  end

endmodule

// File: rtl/mem_intf_hs.sv
// MEM-stage load/store bus interface with valid/ack handshake, wait states and timeout.
module mem_intf_hs
  import mem_intf_hs_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = 32,
  parameter int unsigned BUS_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_req,
  input  logic                          i_we,
  input  logic [1:0]                    i_size,
  input  logic                          i_signed,
  input  logic [BUS_ADDR_WIDTH-1:0]     i_addr,
  input  logic [BUS_DATA_WIDTH-1:0]     i_st_data,
  output logic                          o_stall,
  output logic                          o_ld_valid,
  output logic [BUS_DATA_WIDTH-1:0]     o_ld_data,
  output logic                          o_addr_err,
  output logic                          o_bus_err,
  output logic                          o_bus_req,
  output logic                          o_bus_we,
  output logic [BUS_DATA_WIDTH/8-1:0]   o_bus_be,
  output logic [BUS_ADDR_WIDTH-1:0]     o_bus_addr,
  output logic [BUS_DATA_WIDTH-1:0]     o_bus_data,
  input  logic                          i_bus_ack,
  input  logic [BUS_DATA_WIDTH-1:0]     i_bus_data
);

  localparam int unsigned DW    = BUS_DATA_WIDTH;
  localparam int unsigned AW    = BUS_ADDR_WIDTH;
  localparam int unsigned BEW   = DW / 8;
  localparam int unsigned OFF_W = $clog2(BEW);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  acc_ctx_t         ctx_q, ctx_d;
  logic [OFF_W-1:0] off_q, off_d;

  logic             ld_valid_d, addr_err_d, bus_err_d, bus_req_d, bus_we_d;
  logic [DW-1:0]    ld_data_d, bus_data_d;
  logic [BEW-1:0]   bus_be_d;
  logic [AW-1:0]    bus_addr_d;

  logic             legal_c, take_c, bad_c, ack_c, tmo_c;
  logic [BEW-1:0]   be_c;
  logic [DW-1:0]    st_data_c, ld_ext_c;

  mem_intf_hs_lane_align #(
    .DW    (DW),
    .OFF_W (OFF_W)
  ) u_lane_align (
    .st_size   (size_e'(i_size)),
    .st_off    (i_addr[OFF_W-1:0]),
    .st_data   (i_st_data),
    .ld_size   (ctx_q.size),
    .ld_off    (off_q),
    .ld_sgn    (ctx_q.sgn),
    .ld_raw    (i_bus_data),
    .legal_c   (legal_c),
    .be_c      (be_c),
    .st_data_c (st_data_c),
    .ld_data_c (ld_ext_c)
  );

  // Request qualification and WAIT-phase completion events
  always_comb begin
    take_c = (state_q != ST_WAIT) & i_req & legal_c;
    bad_c  = (state_q != ST_WAIT) & i_req & ~legal_c;
    ack_c  = (state_q == ST_WAIT) & i_bus_ack;
    tmo_c  = (state_q == ST_WAIT) & ~i_bus_ack & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Pipeline hold: outstanding transaction, or a legal access being accepted now
  assign o_stall = (state_q == ST_WAIT) | take_c;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; RESP accepts a new access exactly like IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RESP: state_d = take_c ? ST_WAIT : ST_IDLE;
      ST_WAIT:          if (ack_c || tmo_c) state_d = ST_RESP;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, access context and timeout counter
  always_comb begin
    ctx_d      = ctx_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    ld_valid_d = 1'b0;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    ld_data_d  = o_ld_data;
    bus_req_d  = o_bus_req;
    bus_we_d   = o_bus_we;
    bus_be_d   = o_bus_be;
    bus_addr_d = o_bus_addr;
    bus_data_d = o_bus_data;

    if (take_c) begin
      ctx_d.we   = i_we;
      ctx_d.size = size_e'(i_size);
      ctx_d.sgn  = i_signed;
      off_d      = i_addr[OFF_W-1:0];
      cnt_d      = '0;
      bus_req_d  = 1'b1;
      bus_we_d   = i_we;
      bus_be_d   = be_c;
      bus_addr_d = {i_addr[AW-1:OFF_W], {OFF_W{1'b0}}};
      bus_data_d = st_data_c;
    end

    if (bad_c) addr_err_d = 1'b1;

    if (ack_c) begin
      bus_req_d = 1'b0;
      cnt_d     = '0;
      if (!ctx_q.we) begin
        ld_data_d  = ld_ext_c;
        ld_valid_d = 1'b1;
      end
    end else if (tmo_c) begin
      bus_req_d = 1'b0;
      bus_err_d = 1'b1;
      ld_data_d = '0;
      cnt_d     = '0;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output, context and counter registers; reset abandons any outstanding access silently
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctx_q      <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      o_ld_valid <= 1'b0;
      o_ld_data  <= '0;
      o_addr_err <= 1'b0;
      o_bus_err  <= 1'b0;
      o_bus_req  <= 1'b0;
      o_bus_we   <= 1'b0;
      o_bus_be   <= '0;
      o_bus_addr <= '0;
      o_bus_data <= '0;
    end else begin
      ctx_q      <= ctx_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      o_ld_valid <= ld_valid_d;
      o_ld_data  <= ld_data_d;
      o_addr_err <= addr_err_d;
      o_bus_err  <= bus_err_d;
      o_bus_req  <= bus_req_d;
      o_bus_we   <= bus_we_d;
      o_bus_be   <= bus_be_d;
      o_bus_addr <= bus_addr_d;
      o_bus_data <= bus_data_d;
    end
  end

endmodule

// File: tb/tb_mem_intf_hs.sv
// Self-checking bench for mem_intf_hs (32-bit bus, TIMEOUT_CYCLES=4) with a load-result scoreboard.
module tb_mem_intf_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, sgn;
  logic [1:0]  size;
  logic [31:0] addr, st_data;
  logic        stall, ld_valid, addr_err, bus_err, bus_req, bus_we;
  logic [31:0] ld_data, bus_addr, bus_data;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_intf_hs #(
    .BUS_DATA_WIDTH (32),
    .BUS_ADDR_WIDTH (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_we       (we),
    .i_size     (size),
    .i_signed   (sgn),
    .i_addr     (addr),
    .i_st_data  (st_data),
    .o_stall    (stall),
    .o_ld_valid (ld_valid),
    .o_ld_data  (ld_data),
    .o_addr_err (addr_err),
    .o_bus_err  (bus_err),
    .o_bus_req  (bus_req),
    .o_bus_we   (bus_we),
    .o_bus_be   (bus_be),
    .o_bus_addr (bus_addr),
    .o_bus_data (bus_data),
    .i_bus_ack  (bus_ack),
    .i_bus_data (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] raw, input logic [1:0] sz,
                                           input logic s, input logic [1:0] off);
    logic [31:0] sh;
    sh = raw >> (8 * off);
    case (sz)
      2'd0:    return s ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      2'd1:    return s ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic [3:0] be_model(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Scoreboard: every load result or bus error must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (ld_valid || bus_err)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", {ld_valid, bus_err}, 0);
      end else begin
        e = sb.pop_front();
        check("sb_err", bus_err, e.err);
        check("sb_valid", ld_valid, !e.err);
        check("sb_data", ld_data, e.data);
      end
    end
  end

  // One legal access with ack after dly cycles of o_bus_req (dly>=1)
  task automatic run_access(input logic w, input logic [1:0] sz, input logic s,
                            input logic [31:0] a, input logic [31:0] st, input int dly,
                            input logic [31:0] rdata, input logic [3:0] ebe,
                            input logic [31:0] ebdata, input logic [31:0] eld);
    cyc();
    req = 1'b1; we = w; size = sz; sgn = s; addr = a; st_data = st;
    if (!w) sb.push_back('{1'b0, eld});
    smp();
    check("stall_req", stall, 1);
    cyc();
    req = 1'b0;
    for (int j = 1; j <= dly; j++) begin
      if (j == dly) begin
        bus_ack = 1'b1;
        bus_rdata = rdata;
      end
      smp();
      check("wait_bus_req", bus_req, 1);
      check("wait_stall", stall, 1);
      check("wait_we", bus_we, w);
      check("wait_be", bus_be, ebe);
      check("wait_addr", bus_addr, {a[31:2], 2'b00});
      if (w) check("wait_data", bus_data, ebdata);
      cyc();
    end
    bus_ack = 1'b0;
    bus_rdata = $urandom;
    smp();
    check("resp_bus_req", bus_req, 0);
    check("resp_stall", stall, 0);
    check("resp_valid", ld_valid, !w);
  endtask

  // Illegal access: one-cycle o_addr_err, no bus activity, no stall
  task automatic misaligned(input logic [1:0] sz, input logic [31:0] a);
    cyc();
    req = 1'b1; we = 1'b0; size = sz; sgn = 1'b0; addr = a;
    smp();
    check("mis_stall", stall, 0);
    cyc();
    req = 1'b0;
    smp();
    check("mis_addr_err", addr_err, 1);
    check("mis_bus_req", bus_req, 0);
    check("mis_stall_after", stall, 0);
    cyc();
    smp();
    check("mis_err_pulse", addr_err, 0);
    check("mis_bus_req2", bus_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rsz, roff;
    logic        rs;
    logic [31:0] raddr, rdat;

    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sgn = 1'b0;
    addr = '0; st_data = '0; bus_ack = 1'b0; bus_rdata = '0;

    repeat (2) @(posedge clk);
    smp();
    check("rst_bus_req", bus_req, 0);
    check("rst_stall", stall, 0);
    check("rst_ld_valid", ld_valid, 0);
    check("rst_ld_data", ld_data, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_bus_be", bus_be, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_data", bus_data, 0);
    cyc();
    rst = 1'b0;

    // Load word, ack 3 cycles after the request
    run_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 4'hF, 32'h0, 32'hDEADBEEF);
    cyc();
    smp();
    check("ld_valid_pulse", ld_valid, 0);
    check("ld_data_hold", ld_data, 32'hDEADBEEF);

    // Byte loads from the top lane, signed then unsigned
    run_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1, 32'h80000000, 4'h8, 32'h0, 32'hFFFFFF80);
    run_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 2, 32'h80000000, 4'h8, 32'h0, 32'h00000080);

    // Store half to upper lanes; load result must not change
    run_access(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234, 2, 32'hCAFEF00D, 4'hC, 32'h12340000, 32'h0);
    check("st_keeps_ld", ld_data, 32'h00000080);

    // Illegal accesses
    misaligned(2'd2, 32'h101);
    misaligned(2'd3, 32'h100);
    misaligned(2'd1, 32'h105);

    // Timeout: no ack for 4 WAIT cycles, then a late ack that must be ignored
    cyc();
    req = 1'b1; we = 1'b0; size = 2'd2; sgn = 1'b0; addr = 32'h200;
    sb.push_back('{1'b1, 32'h0});
    smp();
    check("tmo_stall", stall, 1);
    cyc();
    req = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      smp();
      check("tmo_bus_req", bus_req, 1);
      check("tmo_no_err", bus_err, 0);
      cyc();
    end
    bus_ack = 1'b1;
    bus_rdata = 32'h12345678;
    smp();
    check("tmo_req_drop", bus_req, 0);
    check("tmo_bus_err", bus_err, 1);
    check("tmo_ld_data", ld_data, 0);
    check("tmo_stall_after", stall, 0);
    cyc();
    bus_ack = 1'b0;
    smp();
    check("late_ack_valid", ld_valid, 0);
    check("late_ack_err", bus_err, 0);
    check("late_ack_req", bus_req, 0);
    check("late_ack_data", ld_data, 0);

    // Mid-transaction reset during a store's WAIT phase
    cyc();
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h300; st_data = 32'hA5A5A5A5;
    smp();
    cyc();
    req = 1'b0;
    smp();
    check("mrst_pre_req", bus_req, 1);
    check("mrst_pre_data", bus_data, 32'hA5A5A5A5);
    cyc();
    rst = 1'b1;
    #1;
    check("mrst_bus_req", bus_req, 0);
    check("mrst_bus_be", bus_be, 0);
    check("mrst_bus_addr", bus_addr, 0);
    check("mrst_bus_data", bus_data, 0);
    check("mrst_bus_we", bus_we, 0);
    check("mrst_stall", stall, 0);
    cyc();
    rst = 1'b0;
    run_access(1'b0, 2'd2, 1'b1, 32'h304, 32'h0, 1, 32'h7F00FF01, 4'hF, 32'h0, 32'h7F00FF01);

    // Back-to-back loads, each acked in the first cycle of its o_bus_req
    cyc();
    req = 1'b1; we = 1'b0; size = 2'd1; sgn = 1'b0; addr = 32'h402;
    sb.push_back('{1'b0, 32'h0000BEEF});
    smp();
    cyc();
    req = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'hBEEF0000;
    smp();
    check("b2b_req1", bus_req, 1);
    cyc();
    bus_ack = 1'b0;
    req = 1'b1; size = 2'd0; sgn = 1'b1; addr = 32'h401;
    sb.push_back('{1'b0, 32'hFFFFFF80});
    smp();
    check("b2b_valid1", ld_valid, 1);
    check("b2b_stall_resp", stall, 1);
    check("b2b_req_gap", bus_req, 0);
    cyc();
    req = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'h00008000;
    smp();
    check("b2b_req2", bus_req, 1);
    check("b2b_between", ld_valid, 0);
    check("b2b_addr2", bus_addr, 32'h400);
    check("b2b_be2", bus_be, 4'h2);
    cyc();
    bus_ack = 1'b0;
    smp();
    check("b2b_valid2", ld_valid, 1);

    // Random aligned loads against the reference model
    for (int i = 0; i < 10; i++) begin
      rsz = 2'($urandom_range(0, 2));
      case (rsz)
        2'd0:    roff = 2'($urandom_range(0, 3));
        2'd1:    roff = 2'($urandom_range(0, 1) * 2);
        default: roff = 2'd0;
      endcase
      rs    = 1'($urandom_range(0, 1));
      rdat  = $urandom;
      raddr = 32'h1000 + 32'(i * 16) + {30'h0, roff};
      run_access(1'b0, rsz, rs, raddr, 32'h0, $urandom_range(1, 3), rdat,
                 be_model(rsz, roff), 32'h0, ld_model(rdat, rsz, rs, roff));
    end

    repeat (3) cyc();
    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
